// File: rtl/jtframe_db9_joy.sv
// Two-pad DB9 Sega/Atari joystick scanner: drives the shared select line, decodes
// 3/6-button Mega Drive pads and publishes active-high button words once per scan.
module jtframe_db9_joy #(
    parameter int SEL_DIV     = 480,
    parameter int IDLE_CYCLES = 96000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        joy1_up_i,
    input  logic        joy1_down_i,
    input  logic        joy1_left_i,
    input  logic        joy1_right_i,
    input  logic        joy1_p6_i,
    input  logic        joy1_p9_i,
    input  logic        joy2_up_i,
    input  logic        joy2_down_i,
    input  logic        joy2_left_i,
    input  logic        joy2_right_i,
    input  logic        joy2_p6_i,
    input  logic        joy2_p9_i,
    output logic        joyX_p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic [1:0]  six_btn,
    output logic [1:0]  md_pad,
    output logic        frame_done
);

    localparam int MAX_CNT = (IDLE_CYCLES > SEL_DIV) ? IDLE_CYCLES : SEL_DIV;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    typedef enum logic {IDLE, SCAN} state_t;

    // Pin order per pad: {p9, p6, up, down, left, right} so bits [5:0] line up with C,B,U,D,L,R.
    logic [1:0][5:0] raw, meta, sync, act;

    assign raw[0] = {joy1_p9_i, joy1_p6_i, joy1_up_i, joy1_down_i, joy1_left_i, joy1_right_i};
    assign raw[1] = {joy2_p9_i, joy2_p6_i, joy2_up_i, joy2_down_i, joy2_left_i, joy2_right_i};
    assign act    = ~sync;

    // NOTE: synchroniser flops reset to the released (high) pin level so no phantom presses appear after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            sync <= '1;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       phase;
    logic             done_pending;
    logic [1:0][11:0] sh_word;
    logic [1:0]       sh_md, sh_six;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            phase        <= '0;
            done_pending <= 1'b0;
            joyX_p7_o    <= 1'b1;
            joy1_o       <= '0;
            joy2_o       <= '0;
            six_btn      <= '0;
            md_pad       <= '0;
            frame_done   <= 1'b0;
            sh_word      <= '0;
            sh_md        <= '0;
            sh_six       <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_pending) begin
                        // Publish the whole scan at once; the idle count starts after this cycle.
                        joy1_o       <= sh_word[0];
                        joy2_o       <= sh_word[1];
                        md_pad       <= sh_md;
                        six_btn      <= sh_six & sh_md;
                        frame_done   <= 1'b1;
                        done_pending <= 1'b0;
                    end else if (cnt == CW'(IDLE_CYCLES - 1)) begin
                        state     <= SCAN;
                        cnt       <= '0;
                        phase     <= '0;
                        joyX_p7_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SCAN: begin
                    if (cnt == CW'(SEL_DIV - 1)) begin
                        for (int p = 0; p < 2; p++) begin
                            case (phase)
                                3'd0: sh_word[p][5:0] <= act[p];
                                3'd1: begin
                                    sh_md[p]         <= act[p][1] & act[p][0];
                                    sh_word[p][7:6]  <= (act[p][1] & act[p][0]) ? act[p][5:4] : 2'b00;
                                end
                                3'd5: sh_six[p] <= &act[p][3:0];
                                3'd6: sh_word[p][11:8] <= (sh_six[p] & sh_md[p]) ?
                                          {act[p][0], act[p][1], act[p][2], act[p][3]} : 4'b0000;
                                default: ;
                            endcase
                        end
                        cnt <= '0;
                        if (phase == 3'd7) begin
                            state        <= IDLE;
                            done_pending <= 1'b1;
                            joyX_p7_o    <= 1'b1;
                        end else begin
                            phase     <= phase + 3'd1;
                            joyX_p7_o <= phase[0];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_db9_joy.sv
// Bench for jtframe_db9_joy: emulates Atari/3-button/6-button pads and checks select timing,
// frame_done spacing and published button words every cycle against a frame-level model.
module tb_jtframe_db9_joy;

    localparam int SEL_C  = 4;
    localparam int IDLE_C = 20;
    localparam int PERIOD = IDLE_C + 8 * SEL_C + 1;

    typedef enum {P_NONE, P_ATARI, P_MD3, P_MD6} pad_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        joyX_p7_o, frame_done;
    logic [11:0] joy1_o, joy2_o;
    logic [1:0]  six_btn, md_pad;
    logic [5:0]  pins1, pins2;

    pad_t        ty1 = P_MD3, ty2 = P_MD3;
    logic [11:0] b1 = '0, b2 = '0;
    int          n6 = 0, hi_run = 0;
    logic        prev_sel = 1'b1;

    int n_cmp = 0, n_bad = 0;

    // Model state: expectations for the frame being scanned and for the words currently shown.
    logic [11:0] nx1, nx2, held1, held2;
    logic [1:0]  nx_six, nx_md, held_six, held_md;
    int          k = 0;

    always #5 clk = ~clk;

    jtframe_db9_joy #(.SEL_DIV(SEL_C), .IDLE_CYCLES(IDLE_C)) dut (
        .clk(clk), .rst(rst),
        .joy1_up_i(pins1[3]), .joy1_down_i(pins1[2]), .joy1_left_i(pins1[1]),
        .joy1_right_i(pins1[0]), .joy1_p6_i(pins1[4]), .joy1_p9_i(pins1[5]),
        .joy2_up_i(pins2[3]), .joy2_down_i(pins2[2]), .joy2_left_i(pins2[1]),
        .joy2_right_i(pins2[0]), .joy2_p6_i(pins2[4]), .joy2_p9_i(pins2[5]),
        .joyX_p7_o(joyX_p7_o), .joy1_o(joy1_o), .joy2_o(joy2_o),
        .six_btn(six_btn), .md_pad(md_pad), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Pad emulation; returns active-low pins {p9, p6, up, down, left, right}.
    function automatic logic [5:0] pad_pins(input pad_t t, input logic [11:0] b, input logic sel, input int n);
        logic [5:0] a;
        case (t)
            P_NONE:  a = 6'b0;
            P_ATARI: a = b[5:0];
            P_MD3:   a = sel ? b[5:0] : {b[7], b[6], b[3], b[2], 2'b11};
            default: begin
                if (!sel && n == 3)     a = {b[7], b[6], 4'b1111};
                else if (sel && n >= 3) a = {b[5], b[4], b[8], b[9], b[10], b[11]};
                else                    a = sel ? b[5:0] : {b[7], b[6], b[3], b[2], 2'b11};
            end
        endcase
        return ~a;
    endfunction

    always_comb begin
        pins1 = pad_pins(ty1, b1, joyX_p7_o, n6);
        pins2 = pad_pins(ty2, b2, joyX_p7_o, n6);
    end

    // 6-button pads count select falls and forget them after a long high period.
    always @(negedge clk) begin
        if (joyX_p7_o) begin
            hi_run = hi_run + 1;
            if (hi_run > 10) n6 = 0;
        end else begin
            if (prev_sel) n6 = n6 + 1;
            hi_run = 0;
        end
        prev_sel = joyX_p7_o;
    end

    function automatic logic [11:0] exp_word(input pad_t t, input logic [11:0] b);
        case (t)
            P_ATARI: return b & 12'h03F;
            P_MD3:   return b & 12'h0FF;
            P_MD6:   return b;
            default: return 12'h000;
        endcase
    endfunction

    task automatic set_pads(input pad_t t1, input logic [11:0] v1, input pad_t t2, input logic [11:0] v2);
        ty1 = t1; b1 = v1; ty2 = t2; b2 = v2;
        nx1    = exp_word(t1, v1);
        nx2    = exp_word(t2, v2);
        nx_md  = {t2 == P_MD3 || t2 == P_MD6, t1 == P_MD3 || t1 == P_MD6};
        nx_six = {t2 == P_MD6, t1 == P_MD6};
    endtask

    // Per-cycle compare: select waveform and frame_done from the frame position, words from the model.
    always @(negedge clk) begin
        int  q, ph;
        logic exp_sel, exp_fd;
        if (rst) begin
            k = 0;
            held1 = '0; held2 = '0; held_six = '0; held_md = '0;
        end else begin
            k = k + 1;
        end
        q      = k % PERIOD;
        exp_fd = (k > 0) && (q == 0);
        if (exp_fd) begin
            held1 = nx1; held2 = nx2; held_six = nx_six; held_md = nx_md;
        end
        if (q < IDLE_C || q >= IDLE_C + 8 * SEL_C) begin
            exp_sel = 1'b1;
        end else begin
            ph      = (q - IDLE_C) / SEL_C;
            exp_sel = (ph % 2 == 0);
        end
        check("sel", joyX_p7_o, exp_sel);
        check("frame_done", frame_done, exp_fd);
        check("joy1", joy1_o, held1);
        check("joy2", joy2_o, held2);
        check("six_btn", six_btn, held_six);
        check("md_pad", md_pad, held_md);
    end

    task automatic wait_fd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 4 * PERIOD);
        #1;
        if (!frame_done) check("fd_timeout", frame_done, 1'b1);
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        int n;
        set_pads(P_MD3, 12'h000, P_MD3, 12'h000);
        wait_neg(3);
        rst = 1'b0;

        // Idle pads: first frame 53 cycles after release, then strictly periodic.
        wait_fd(n);
        check("first_fd_gap", n, 53);
        check("lit_idle_joy1", joy1_o, 12'h000);
        check("lit_idle_md", md_pad, 2'b11);
        check("lit_idle_six", six_btn, 2'b00);
        wait_fd(n);
        check("fd_period", n, 53);

        // 3-button pad 1 and 6-button pad 2 in the same frame.
        set_pads(P_MD3, 12'h0C1, P_MD6, 12'hC10);
        wait_fd(n);
        check("lit_md3_joy1", joy1_o, 12'h0C1);
        check("lit_md6_joy2", joy2_o, 12'hC10);
        check("lit_mix_six", six_btn, 2'b10);
        check("lit_mix_md", md_pad, 2'b11);

        // Atari stick on pad 1, nothing on pad 2.
        set_pads(P_ATARI, 12'h038, P_NONE, 12'h000);
        wait_fd(n);
        check("lit_atari_joy1", joy1_o, 12'h038);
        check("lit_atari_md", md_pad, 2'b00);
        check("lit_unplug_joy2", joy2_o, 12'h000);

        // Buttons change during phase 3: old phase-0/1 bits, new phase-6 bits, published only at frame_done.
        set_pads(P_MD6, 12'h040, P_MD3, 12'h010);
        wait_fd(n);
        wait_neg(33);
        b1  = 12'h400;
        nx1 = 12'h440;
        wait_fd(n);
        check("lit_torn_joy1", joy1_o, 12'h440);
        set_pads(P_MD6, 12'h400, P_MD3, 12'h010);
        wait_fd(n);
        check("lit_after_joy1", joy1_o, 12'h400);

        // Reset during phase 3 with buttons held.
        set_pads(P_MD3, 12'h0C1, P_MD6, 12'hC10);
        wait_fd(n);
        wait_neg(32);
        rst = 1'b1;
        wait_neg(1);
        check("rst_sel", joyX_p7_o, 1'b1);
        check("rst_joy1", joy1_o, 12'h000);
        check("rst_joy2", joy2_o, 12'h000);
        check("rst_six_md", {six_btn, md_pad}, 4'b0000);
        wait_neg(2);
        rst = 1'b0;
        wait_fd(n);
        check("rst_fd_gap", n, 53);
        check("lit_post_rst_joy1", joy1_o, 12'h0C1);
        check("lit_post_rst_six", six_btn, 2'b10);

        wait_neg(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
